// File: rtl/one_hot_mux_pkg.sv
// Shared constants and select-decoding helpers for the one-hot mux pipeline.
// Helpers work on a fixed 64-bit select; callers zero-extend narrower selects.
package one_hot_mux_pkg;

  localparam int unsigned default_width_c       = 8;
  localparam int unsigned default_depth_c       = 8;
  localparam int unsigned default_err_cnt_width_c = 8;
  localparam int unsigned max_depth_c           = 64;

  function automatic logic onehot_legal(input logic [max_depth_c-1:0] oh);
    return ($countones(oh) == 1);
  endfunction

  // OR-reduction encoder: exact for legal one-hot inputs, don't-care otherwise.
  function automatic logic [6:0] onehot_to_idx(input logic [max_depth_c-1:0] oh);
    logic [6:0] idx;
    idx = '0;
    for (int i = 0; i < max_depth_c; i++) begin
      if (oh[i]) idx = idx | 7'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/one_hot_mux.sv
// Combinational AND-OR selector of depth_p channels by a one-hot select.
module one_hot_mux #(
  parameter int unsigned width_p = 8,
  parameter int unsigned depth_p = 8
) (
  input  logic [depth_p*width_p-1:0] data_i,
  input  logic [depth_p-1:0]         sel_i,
  output logic [width_p-1:0]         data_o
);

  always_comb begin
    data_o = '0;
    for (int k = 0; k < depth_p; k++) begin
      data_o = data_o | (data_i[k*width_p +: width_p] & {width_p{sel_i[k]}});
    end
  end

endmodule

// File: rtl/one_hot_mux_pipe.sv
// One-hot channel select with a single registered output stage and valid/ready handshake.
// Illegal selects are consumed and dropped, raising a sticky flag and a saturating counter.
module one_hot_mux_pipe
  import one_hot_mux_pkg::*;
#(
  parameter int unsigned width_p         = default_width_c,
  parameter int unsigned depth_p         = default_depth_c,
  parameter int unsigned err_cnt_width_p = default_err_cnt_width_c
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [depth_p*width_p-1:0]   data_i,
  input  logic [depth_p-1:0]           sel_one_hot_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [width_p-1:0]           data_o,
  output logic [$clog2(depth_p)-1:0]   sel_idx_o,
  output logic                         err_o,
  output logic [err_cnt_width_p-1:0]   err_cnt_o,
  input  logic                         err_clr_i
);

  localparam int unsigned idx_w_lp = $clog2(depth_p);

  logic                       valid_q, valid_d;
  logic [width_p-1:0]         data_q, data_d;
  logic [idx_w_lp-1:0]        idx_q, idx_d;
  logic                       err_q, err_d;
  logic [err_cnt_width_p-1:0] cnt_q, cnt_d;

  logic [width_p-1:0]         mux_data;
  logic [max_depth_c-1:0]     sel_ext;
  logic                       sel_legal;
  logic                       in_xfer;
  logic                       out_xfer;

  one_hot_mux #(
    .width_p (width_p),
    .depth_p (depth_p)
  ) u_mux (
    .data_i (data_i),
    .sel_i  (sel_one_hot_i),
    .data_o (mux_data)
  );

  assign sel_ext   = max_depth_c'(sel_one_hot_i);
  assign sel_legal = onehot_legal(sel_ext);
  assign ready_o   = !valid_q || ready_i;
  assign in_xfer   = valid_i && ready_o;
  assign out_xfer  = valid_q && ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    if (out_xfer) valid_d = 1'b0;
    if (in_xfer && sel_legal) begin
      valid_d = 1'b1;
      data_d  = mux_data;
      idx_d   = idx_w_lp'(onehot_to_idx(sel_ext));
    end
  end

  // Clear takes priority over a coincident illegal beat.
  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (err_clr_i) begin
      err_d = 1'b0;
      cnt_d = '0;
    end else if (in_xfer && !sel_legal) begin
      err_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign sel_idx_o = idx_q;
  assign err_o     = err_q;
  assign err_cnt_o = cnt_q;

endmodule
